fc_inference_scheduler: RTL and testbench

FC_INFERENCE_SCHEDULER -- requirements
Module: fc_inference_scheduler

---
 rtl/fc_inference_scheduler.sv | 124 ++++++++++++
 tb/tb_fc_inference_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fc_inference_scheduler.sv
// Sequences a chain of FC layers one run pulse at a time with a per-layer watchdog,
// and arbitrates the shared input BRAM between the host (idle) and the layers (busy).
module fc_inference_scheduler #(
   parameter int NUM_LAYERS     = 2,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 32,
   localparam int LIDX_W        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
   localparam int WD_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_start,
   output logic [NUM_LAYERS-1:0] o_run,
   input  logic [NUM_LAYERS-1:0] i_layer_done,
   input  logic [3:0]            i_mnist_class,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error,
   output logic [3:0]            o_mnist_class,
   output logic [LIDX_W-1:0]     o_layer_idx,
   input  logic                  host_ce,
   input  logic                  host_we,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_din,
   output logic                  host_stall,
   input  logic                  lyr_ce,
   input  logic                  lyr_we,
   input  logic [ADDR_WIDTH-1:0] lyr_addr,
   input  logic [DATA_WIDTH-1:0] lyr_din,
   output logic                  bram_ce,
   output logic                  bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_din
);

   typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE, S_ERROR} state_t;

   state_t            state_q, state_d;
   logic [LIDX_W-1:0] layer_idx_q, layer_idx_d;
   logic [WD_W-1:0]   watchdog_q, watchdog_d;
   logic              error_q, error_d;
   logic [3:0]        class_q, class_d;
   logic              done_match;
   logic              is_last;

   assign done_match = i_layer_done[layer_idx_q];
   assign is_last    = (layer_idx_q == LIDX_W'(NUM_LAYERS - 1));

   always_comb begin
      state_d     = state_q;
      layer_idx_d = layer_idx_q;
      watchdog_d  = watchdog_q;
      error_d     = error_q;
      class_d     = class_q;
      case (state_q)
         S_IDLE: begin
            // Host owns the BRAM in IDLE, so a start coinciding with host access waits.
            if (i_start && !host_ce) begin
               state_d     = S_LAUNCH;
               layer_idx_d = '0;
               error_d     = 1'b0;
            end
         end
         S_LAUNCH: begin
            watchdog_d = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            watchdog_d = watchdog_q + WD_W'(1);
            if (done_match) begin
               if (is_last) begin
                  state_d = S_DONE;
                  class_d = i_mnist_class;
               end else begin
                  layer_idx_d = layer_idx_q + LIDX_W'(1);
                  state_d     = S_LAUNCH;
               end
            end else if (watchdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_ERROR;
            end
         end
         S_DONE: state_d = S_IDLE;
         S_ERROR: begin
            error_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         layer_idx_q <= '0;
         watchdog_q  <= '0;
         error_q     <= 1'b0;
         class_q     <= 4'd0;
      end else begin
         state_q     <= state_d;
         layer_idx_q <= layer_idx_d;
         watchdog_q  <= watchdog_d;
         error_q     <= error_d;
         class_q     <= class_d;
      end
   end

   for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_run
      assign o_run[gi] = (state_q == S_LAUNCH) && (layer_idx_q == LIDX_W'(gi));
   end

   assign o_busy        = (state_q != S_IDLE);
   assign o_done        = (state_q == S_DONE);
   assign o_error       = error_q;
   assign o_mnist_class = class_q;
   assign o_layer_idx   = layer_idx_q;
   assign host_stall    = o_busy && host_ce;

   assign bram_ce   = o_busy ? lyr_ce   : host_ce;
   assign bram_we   = o_busy ? lyr_we   : host_we;
   assign bram_addr = o_busy ? lyr_addr : host_addr;
   assign bram_din  = o_busy ? lyr_din  : host_din;

endmodule

// File: tb/tb_fc_inference_scheduler.sv
// Directed bench for fc_inference_scheduler with two layers and a 16-cycle watchdog.
module tb_fc_inference_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_start;
   logic [1:0]  o_run;
   logic [1:0]  i_layer_done;
   logic [3:0]  i_mnist_class;
   logic        o_busy, o_done, o_error;
   logic [3:0]  o_mnist_class;
   logic [0:0]  o_layer_idx;
   logic        host_ce, host_we, host_stall;
   logic [11:0] host_addr;
   logic [31:0] host_din;
   logic        lyr_ce, lyr_we;
   logic [11:0] lyr_addr;
   logic [31:0] lyr_din;
   logic        bram_ce, bram_we;
   logic [11:0] bram_addr;
   logic [31:0] bram_din;

   int tests = 0;
   int fails = 0;

   fc_inference_scheduler #(
      .NUM_LAYERS(2), .TIMEOUT_CYCLES(16), .ADDR_WIDTH(12), .DATA_WIDTH(32)
   ) dut (
      .clk(clk), .reset(reset), .i_start(i_start), .o_run(o_run),
      .i_layer_done(i_layer_done), .i_mnist_class(i_mnist_class),
      .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
      .o_mnist_class(o_mnist_class), .o_layer_idx(o_layer_idx),
      .host_ce(host_ce), .host_we(host_we), .host_addr(host_addr),
      .host_din(host_din), .host_stall(host_stall),
      .lyr_ce(lyr_ce), .lyr_we(lyr_we), .lyr_addr(lyr_addr), .lyr_din(lyr_din),
      .bram_ce(bram_ce), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      host_ce = 1'b1;
      #3;
      tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", o_busy); end
      tests++; if (o_run !== 2'b00) begin fails++; $display("FAIL reset_run: got %b expected 00", o_run); end
      tests++; if (o_done !== 1'b0 || o_error !== 1'b0) begin fails++; $display("FAIL reset_done_err: got %b%b expected 00", o_done, o_error); end
      tests++; if (o_mnist_class !== 4'd0) begin fails++; $display("FAIL reset_class: got %0d expected 0", o_mnist_class); end
      tests++; if (host_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b expected 0", host_stall); end
      tests++; if (o_layer_idx !== 1'b0) begin fails++; $display("FAIL reset_idx: got %0d expected 0", o_layer_idx); end
      @(negedge clk); host_ce = 1'b0; reset = 1'b0;
      $display("[TB] test_reset complete");
   endtask

   task automatic test_normal_pass();
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      tests++; if (o_run !== 2'b01) begin fails++; $display("FAIL norm_run0: got %b expected 01", o_run); end
      tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL norm_busy: got %0b expected 1", o_busy); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++; if (o_run !== 2'b00) begin fails++; $display("FAIL norm_wait0_run: got %b expected 00", o_run); end
      end
      @(negedge clk); i_layer_done = 2'b01;
      @(negedge clk); i_layer_done = 2'b00;
      tests++; if (o_run !== 2'b10) begin fails++; $display("FAIL norm_run1: got %b expected 10", o_run); end
      tests++; if (o_layer_idx !== 1'b1) begin fails++; $display("FAIL norm_idx1: got %0d expected 1", o_layer_idx); end
      repeat (2) @(negedge clk);
      tests++; if (o_done !== 1'b0) begin fails++; $display("FAIL norm_early_done: got %0b expected 0", o_done); end
      @(negedge clk); i_layer_done = 2'b10; i_mnist_class = 4'd7;
      @(negedge clk); i_layer_done = 2'b00; i_mnist_class = 4'd0;
      tests++; if (o_done !== 1'b1) begin fails++; $display("FAIL norm_done: got %0b expected 1", o_done); end
      tests++; if (o_mnist_class !== 4'd7) begin fails++; $display("FAIL norm_class: got %0d expected 7", o_mnist_class); end
      @(negedge clk);
      tests++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL norm_after: got done=%0b busy=%0b expected 0 0", o_done, o_busy); end
      tests++; if (o_mnist_class !== 4'd7) begin fails++; $display("FAIL norm_class_hold: got %0d expected 7", o_mnist_class); end
      $display("[TB] test_normal_pass complete");
   endtask

   task automatic test_timeout();
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      tests++; if (o_run !== 2'b01) begin fails++; $display("FAIL to_run0: got %b expected 01", o_run); end
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         tests++; if (o_run !== 2'b00 || o_busy !== 1'b1 || o_error !== 1'b0) begin fails++; $display("FAIL to_wait cycle %0d: got run=%b busy=%0b err=%0b expected 00 1 0", i, o_run, o_busy, o_error); end
      end
      @(negedge clk);
      tests++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin fails++; $display("FAIL to_errstate: got busy=%0b done=%0b expected 1 0", o_busy, o_done); end
      @(negedge clk);
      tests++; if (o_error !== 1'b1 || o_busy !== 1'b0) begin fails++; $display("FAIL to_error: got err=%0b busy=%0b expected 1 0", o_error, o_busy); end
      repeat (3) @(negedge clk);
      tests++; if (o_error !== 1'b1 || o_done !== 1'b0) begin fails++; $display("FAIL to_sticky: got err=%0b done=%0b expected 1 0", o_error, o_done); end
      $display("[TB] test_timeout complete");
   endtask

   task automatic test_done_at_timeout();
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      tests++; if (o_error !== 1'b0) begin fails++; $display("FAIL dt_err_clear: got %0b expected 0", o_error); end
      repeat (15) @(negedge clk);
      @(negedge clk); i_layer_done = 2'b01;
      @(negedge clk); i_layer_done = 2'b00;
      tests++; if (o_run !== 2'b10 || o_error !== 1'b0) begin fails++; $display("FAIL dt_advance: got run=%b err=%0b expected 10 0", o_run, o_error); end
      @(negedge clk); i_layer_done = 2'b10; i_mnist_class = 4'd3;
      @(negedge clk); i_layer_done = 2'b00; i_mnist_class = 4'd0;
      tests++; if (o_done !== 1'b1 || o_mnist_class !== 4'd3) begin fails++; $display("FAIL dt_done: got done=%0b class=%0d expected 1 3", o_done, o_mnist_class); end
      @(negedge clk);
      tests++; if (o_busy !== 1'b0 || o_error !== 1'b0) begin fails++; $display("FAIL dt_after: got busy=%0b err=%0b expected 0 0", o_busy, o_error); end
      $display("[TB] test_done_at_timeout complete");
   endtask

   task automatic test_host_mux();
      @(negedge clk);
      host_ce = 1'b1; host_we = 1'b1; host_addr = 12'h005; host_din = 32'h0000_00A5;
      lyr_ce = 1'b1; lyr_we = 1'b0; lyr_addr = 12'h03C; lyr_din = 32'h0000_1234;
      i_start = 1'b1;
      #1;
      tests++; if (bram_ce !== 1'b1 || bram_we !== 1'b1 || bram_addr !== 12'h005 || bram_din !== 32'hA5) begin fails++; $display("FAIL host_idle_bram: got ce=%0b we=%0b addr=%h din=%h expected 1 1 005 a5", bram_ce, bram_we, bram_addr, bram_din); end
      tests++; if (host_stall !== 1'b0) begin fails++; $display("FAIL host_idle_stall: got %0b expected 0", host_stall); end
      @(negedge clk);
      tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL host_priority: got busy=%0b expected 0", o_busy); end
      host_ce = 1'b0; host_we = 1'b0;
      @(negedge clk); i_start = 1'b0;
      tests++; if (o_run !== 2'b01) begin fails++; $display("FAIL host_run0: got %b expected 01", o_run); end
      @(negedge clk);
      host_ce = 1'b1; host_we = 1'b1;
      #1;
      tests++; if (host_stall !== 1'b1) begin fails++; $display("FAIL host_busy_stall: got %0b expected 1", host_stall); end
      tests++; if (bram_we !== 1'b0 || bram_addr !== 12'h03C || bram_din !== 32'h1234) begin fails++; $display("FAIL host_busy_bram: got we=%0b addr=%h din=%h expected 0 03c 1234", bram_we, bram_addr, bram_din); end
      @(negedge clk); host_ce = 1'b0; host_we = 1'b0; i_layer_done = 2'b01;
      @(negedge clk); i_layer_done = 2'b00;
      @(negedge clk); i_layer_done = 2'b10; i_mnist_class = 4'd9;
      @(negedge clk); i_layer_done = 2'b00; i_mnist_class = 4'd0;
      tests++; if (o_done !== 1'b1 || o_mnist_class !== 4'd9) begin fails++; $display("FAIL host_pass_done: got done=%0b class=%0d expected 1 9", o_done, o_mnist_class); end
      @(negedge clk);
      lyr_ce = 1'b0; lyr_addr = 12'h000; lyr_din = 32'h0;
      $display("[TB] test_host_mux complete");
   endtask

   task automatic test_spurious();
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      @(negedge clk); i_layer_done = 2'b10; i_start = 1'b1; i_mnist_class = 4'd11;
      @(negedge clk); i_layer_done = 2'b00; i_start = 1'b0; i_mnist_class = 4'd0;
      tests++; if (o_run !== 2'b00 || o_layer_idx !== 1'b0 || o_busy !== 1'b1 || o_done !== 1'b0) begin fails++; $display("FAIL sp_ignored: got run=%b idx=%0d busy=%0b done=%0b expected 00 0 1 0", o_run, o_layer_idx, o_busy, o_done); end
      @(negedge clk); i_layer_done = 2'b01;
      @(negedge clk); i_layer_done = 2'b00;
      tests++; if (o_run !== 2'b10) begin fails++; $display("FAIL sp_run1: got %b expected 10", o_run); end
      @(negedge clk); i_layer_done = 2'b10; i_mnist_class = 4'd5;
      @(negedge clk); i_layer_done = 2'b00; i_mnist_class = 4'd0;
      tests++; if (o_done !== 1'b1 || o_mnist_class !== 4'd5) begin fails++; $display("FAIL sp_done: got done=%0b class=%0d expected 1 5", o_done, o_mnist_class); end
      @(negedge clk);
      tests++; if (o_busy !== 1'b0 || o_run !== 2'b00) begin fails++; $display("FAIL sp_no_requeue: got busy=%0b run=%b expected 0 00", o_busy, o_run); end
      $display("[TB] test_spurious complete");
   endtask

   task automatic test_reset_mid_pass();
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      @(negedge clk); i_layer_done = 2'b01;
      @(negedge clk); i_layer_done = 2'b00;
      tests++; if (o_run !== 2'b10) begin fails++; $display("FAIL rm_run1: got %b expected 10", o_run); end
      @(negedge clk); reset = 1'b1; host_ce = 1'b1;
      #1;
      tests++; if (o_busy !== 1'b0 || o_run !== 2'b00 || o_done !== 1'b0 || o_error !== 1'b0) begin fails++; $display("FAIL rm_async: got busy=%0b run=%b done=%0b err=%0b expected 0 00 0 0", o_busy, o_run, o_done, o_error); end
      tests++; if (o_mnist_class !== 4'd0 || o_layer_idx !== 1'b0 || host_stall !== 1'b0) begin fails++; $display("FAIL rm_regs: got class=%0d idx=%0d stall=%0b expected 0 0 0", o_mnist_class, o_layer_idx, host_stall); end
      @(negedge clk); reset = 1'b0; host_ce = 1'b0;
      @(negedge clk); i_layer_done = 2'b10; i_mnist_class = 4'd2;
      @(negedge clk); i_layer_done = 2'b00; i_mnist_class = 4'd0;
      tests++; if (o_done !== 1'b0 || o_busy !== 1'b0 || o_mnist_class !== 4'd0) begin fails++; $display("FAIL rm_stray_done: got done=%0b busy=%0b class=%0d expected 0 0 0", o_done, o_busy, o_mnist_class); end
      i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      tests++; if (o_run !== 2'b01 || o_layer_idx !== 1'b0) begin fails++; $display("FAIL rm_restart: got run=%b idx=%0d expected 01 0", o_run, o_layer_idx); end
      @(negedge clk); i_layer_done = 2'b01;
      @(negedge clk); i_layer_done = 2'b00;
      @(negedge clk); i_layer_done = 2'b10; i_mnist_class = 4'd4;
      @(negedge clk); i_layer_done = 2'b00; i_mnist_class = 4'd0;
      tests++; if (o_done !== 1'b1 || o_mnist_class !== 4'd4) begin fails++; $display("FAIL rm_finish: got done=%0b class=%0d expected 1 4", o_done, o_mnist_class); end
      @(negedge clk);
      $display("[TB] test_reset_mid_pass complete");
   endtask

   initial begin
      reset = 1'b1; i_start = 1'b0; i_layer_done = 2'b00; i_mnist_class = 4'd0;
      host_ce = 1'b0; host_we = 1'b0; host_addr = '0; host_din = '0;
      lyr_ce = 1'b0; lyr_we = 1'b0; lyr_addr = '0; lyr_din = '0;
      test_reset();
      test_normal_pass();
      test_timeout();
      test_done_at_timeout();
      test_host_mux();
      test_spurious();
      test_reset_mid_pass();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
